// File: rtl/spad_capture.sv
// spad_capture: SPAD/TDC capture front end.
// Launches a frame with TDC_start, runs a 9-bit coarse counter across the
// frame, timestamps each synchronized trig rising edge together with spad_int,
// re-arms the SPAD and streams hits out on a valid/ready interface.
// Optional feature macro: SPAD_CAPTURE_FIFO_EN selects a 4-entry hit FIFO
// instead of the single output register used by default.
module spad_capture (
  input  logic        clk_250M,
  input  logic        rst_auto,
  input  logic        start_req,
  output logic        TDC_start,
  input  logic        trig,
  input  logic        time_gate,
  input  logic [15:0] spad_int,
  output logic        spad_rearm,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic [1:0]  hit_idx,
  output logic [8:0]  hit_coarse,
  output logic [15:0] hit_int,
  output logic        frame_done,
  output logic        hit_ovf
);

  localparam int RANGE_CYC = 512;
  localparam int MAX_HITS  = 3;
  localparam int REARM_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARMED,
    S_REARM,
    S_WAIT_LOW,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        trig_meta;
  logic        trig_s;
  logic        trig_s_d;
  logic        trig_rise;
  logic [8:0]  cnt;
  logic [1:0]  hit_cnt;
  logic [1:0]  rearm_cnt;
  logic        counting;
  logic        range_end;
  logic        capture;
  logic        store_ok;
  logic [8:0]  stamp;
  logic        unused_inputs;

  assign unused_inputs = time_gate;

  assign trig_rise = trig_s & ~trig_s_d;
  assign counting  = (state == S_ARMED) || (state == S_REARM) || (state == S_WAIT_LOW);
  assign range_end = counting && (cnt == 9'(RANGE_CYC - 2));
  assign stamp     = (cnt >= 9'd2) ? (cnt - 9'd2) : 9'd0;

  // Two-flop synchronizer for the asynchronous trig plus a delayed copy for edge detect
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_s_d  <= 1'b0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      trig_s_d  <= trig_s;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state strobes; range expiry wins over a same-cycle edge
  always_comb begin
    state_nx   = state;
    capture    = 1'b0;
    TDC_start  = 1'b0;
    spad_rearm = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) state_nx = S_START;
      end
      S_START: begin
        TDC_start = 1'b1;
        state_nx  = S_ARMED;
      end
      S_ARMED: begin
        if (range_end) begin
          state_nx = S_DONE;
        end else if (trig_rise) begin
          capture  = 1'b1;
          state_nx = S_REARM;
        end
      end
      S_REARM: begin
        spad_rearm = 1'b1;
        if (range_end) begin
          state_nx = S_DONE;
        end else if (rearm_cnt == 2'(REARM_CYC - 1)) begin
          state_nx = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (range_end) begin
          state_nx = S_DONE;
        end else if (!trig_s) begin
          state_nx = (hit_cnt == 2'(MAX_HITS)) ? S_DONE : S_ARMED;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        spad_rearm = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Coarse counter, hit counter, re-arm pulse timer and sticky overflow flag
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      cnt       <= 9'd0;
      hit_cnt   <= 2'd0;
      rearm_cnt <= 2'd0;
      hit_ovf   <= 1'b0;
    end else begin
      if (state == S_START) begin
        cnt     <= 9'd0;
        hit_cnt <= 2'd0;
        hit_ovf <= 1'b0;
      end else begin
        if (counting) cnt <= cnt + 9'd1;
        if (capture) hit_cnt <= hit_cnt + 2'd1;
        if (capture && !store_ok) hit_ovf <= 1'b1;
      end
      if (capture) begin
        rearm_cnt <= 2'd0;
      end else if (state == S_REARM) begin
        rearm_cnt <= rearm_cnt + 2'd1;
      end
    end
  end

`ifdef SPAD_CAPTURE_FIFO_EN

  logic [26:0] mem [4];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [2:0]  fill;
  logic        pop;

  assign fill      = wr_ptr - rd_ptr;
  assign hit_valid = (wr_ptr != rd_ptr);
  assign pop       = hit_valid & hit_ready;
  assign store_ok  = (fill != 3'd4) || pop;
  assign {hit_idx, hit_coarse, hit_int} = mem[rd_ptr[1:0]];

  // Four-entry hit FIFO; a pop in the same cycle frees the slot for a write when full
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 27'd0;
    end else begin
      if (capture && store_ok) begin
        mem[wr_ptr[1:0]] <= {hit_cnt, stamp, spad_int};
        wr_ptr           <= wr_ptr + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 3'd1;
    end
  end

`else

  assign store_ok = !hit_valid || hit_ready;

  // Single output register; a hit arriving while the previous one is stalled is dropped
  always_ff @(posedge clk_250M or posedge rst_auto) begin
    if (rst_auto) begin
      hit_valid  <= 1'b0;
      hit_idx    <= 2'd0;
      hit_coarse <= 9'd0;
      hit_int    <= 16'd0;
    end else if (capture && store_ok) begin
      hit_valid  <= 1'b1;
      hit_idx    <= hit_cnt;
      hit_coarse <= stamp;
      hit_int    <= spad_int;
    end else if (hit_ready) begin
      hit_valid  <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_spad_capture.sv
// tb_spad_capture: directed self-checking bench for spad_capture.
// The bench models the SPAD side: trig is raised at a chosen coarse count and
// dropped once spad_rearm is seen. fc tracks the DUT coarse count (0 in the
// cycle after TDC_start). Inputs are driven and outputs sampled on the falling edge.
module tb_spad_capture;

  localparam int NONE = -100;

  logic        clk_250M = 1'b0;
  logic        rst_auto = 1'b1;
  logic        start_req = 1'b0;
  logic        trig = 1'b0;
  logic        time_gate = 1'b0;
  logic [15:0] spad_int = 16'd0;
  logic        hit_ready = 1'b1;
  logic        TDC_start;
  logic        spad_rearm;
  logic        hit_valid;
  logic [1:0]  hit_idx;
  logic [8:0]  hit_coarse;
  logic [15:0] hit_int;
  logic        frame_done;
  logic        hit_ovf;

  int checks = 0;
  int errors = 0;
  int fc;
  int done_fc;
  int valid_cycles;
  int rearm_run;
  int rearm_first;
  logic [1:0]  q_idx[$];
  logic [8:0]  q_coarse[$];
  logic [15:0] q_int[$];

  spad_capture dut (
    .clk_250M   (clk_250M),
    .rst_auto   (rst_auto),
    .start_req  (start_req),
    .TDC_start  (TDC_start),
    .trig       (trig),
    .time_gate  (time_gate),
    .spad_int   (spad_int),
    .spad_rearm (spad_rearm),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_idx    (hit_idx),
    .hit_coarse (hit_coarse),
    .hit_int    (hit_int),
    .frame_done (frame_done),
    .hit_ovf    (hit_ovf)
  );

  // 250 MHz capture clock
  always #2 clk_250M = ~clk_250M;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (hit_valid === 1'b1 && hit_ready === 1'b1) begin
      q_idx.push_back(hit_idx);
      q_coarse.push_back(hit_coarse);
      q_int.push_back(hit_int);
    end
    if (hit_valid === 1'b1) valid_cycles++;
    @(posedge clk_250M);
    @(negedge clk_250M);
    fc++;
    if (frame_done === 1'b1 && done_fc < 0) done_fc = fc;
    if (spad_rearm === 1'b1) begin
      rearm_run++;
      trig = 1'b0;
    end else if (rearm_run > 0) begin
      if (rearm_first < 0) rearm_first = rearm_run;
      rearm_run = 0;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic applyStimulus(input int h0, input int h1, input int h2,
                               input logic [15:0] v0, input logic [15:0] v1,
                               input logic [15:0] v2, input int abort_fc);
    int guard;
    done_fc      = -1;
    valid_cycles = 0;
    rearm_run    = 0;
    rearm_first  = -1;
    q_idx.delete();
    q_coarse.delete();
    q_int.delete();
    start_req = 1'b1;
    @(posedge clk_250M);
    @(negedge clk_250M);
    checkOutput("tdc_start_pulse", {31'd0, TDC_start}, 32'd1);
    start_req = 1'b0;
    fc = -1;
    guard = 0;
    while (done_fc < 0 && fc != abort_fc && guard < 700) begin
      if (fc == h0) begin trig = 1'b1; spad_int = v0; end
      if (fc == h1) begin trig = 1'b1; spad_int = v1; end
      if (fc == h2) begin trig = 1'b1; spad_int = v2; end
      step();
      guard++;
      if (fc == 0) checkOutput("ovf_after_start", {31'd0, hit_ovf}, 32'd0);
    end
    if (abort_fc < 0 && done_fc < 0) checkOutput("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [8:0]  exp_c[3];
    logic [15:0] exp_i[3];
    int          exp_n;

    repeat (3) @(negedge clk_250M);
    checkOutput("reset_outputs",
                {TDC_start, spad_rearm, hit_valid, frame_done, hit_ovf, hit_idx, hit_coarse, hit_int},
                32'd0);
    rst_auto = 1'b0;
    @(negedge clk_250M);

    $display("[TB] single hit at count 100");
    applyStimulus(100, NONE, NONE, 16'h0007, 16'h0000, 16'h0000, NONE);
    checkOutput("single_done_fc", done_fc, 511);
    drain(4);
    checkOutput("single_done_pulse_ends", {31'd0, frame_done}, 32'd0);
    checkOutput("single_count", q_idx.size(), 1);
    if (q_idx.size() >= 1) begin
      checkOutput("single_idx", {30'd0, q_idx[0]}, 32'd0);
      checkOutput("single_coarse", {23'd0, q_coarse[0]}, 32'd100);
      checkOutput("single_int", {16'd0, q_int[0]}, 32'h0007);
    end
    checkOutput("single_rearm_len", rearm_first, 2);

    $display("[TB] three hits at 50/120/300");
    exp_c[0] = 9'd50;  exp_c[1] = 9'd120;  exp_c[2] = 9'd300;
    exp_i[0] = 16'h1111; exp_i[1] = 16'h2222; exp_i[2] = 16'h3333;
    applyStimulus(50, 120, 300, 16'h1111, 16'h2222, 16'h3333, NONE);
    checkOutput("three_done_fc", done_fc, 306);
    drain(4);
    checkOutput("three_count", q_idx.size(), 3);
    for (int i = 0; i < 3 && i < q_idx.size(); i++) begin
      checkOutput($sformatf("three_idx%0d", i), {30'd0, q_idx[i]}, i);
      checkOutput($sformatf("three_coarse%0d", i), {23'd0, q_coarse[i]}, {23'd0, exp_c[i]});
      checkOutput($sformatf("three_int%0d", i), {16'd0, q_int[i]}, {16'd0, exp_i[i]});
    end

    $display("[TB] no hit");
    applyStimulus(NONE, NONE, NONE, 16'h0000, 16'h0000, 16'h0000, NONE);
    checkOutput("nohit_done_fc", done_fc, 511);
    checkOutput("nohit_valid_cycles", valid_cycles, 0);
    drain(4);

    $display("[TB] edge at 508 lost to range expiry");
    applyStimulus(508, NONE, NONE, 16'h00EE, 16'h0000, 16'h0000, NONE);
    checkOutput("late508_done_fc", done_fc, 511);
    drain(4);
    checkOutput("late508_count", q_idx.size(), 0);

    $display("[TB] edge at 507 still captured");
    applyStimulus(507, NONE, NONE, 16'h0507, 16'h0000, 16'h0000, NONE);
    checkOutput("late507_done_fc", done_fc, 511);
    drain(4);
    checkOutput("late507_count", q_idx.size(), 1);
    if (q_idx.size() >= 1) checkOutput("late507_coarse", {23'd0, q_coarse[0]}, 32'd507);

    $display("[TB] backpressure with three hits");
    hit_ready = 1'b0;
    applyStimulus(50, 120, 300, 16'h0A0A, 16'h0B0B, 16'h0C0C, NONE);
    checkOutput("bp_done_fc", done_fc, 306);
`ifdef SPAD_CAPTURE_FIFO_EN
    checkOutput("bp_ovf", {31'd0, hit_ovf}, 32'd0);
    exp_n = 3;
`else
    checkOutput("bp_ovf", {31'd0, hit_ovf}, 32'd1);
    exp_n = 1;
`endif
    drain(3);
    checkOutput("bp_hold_valid", {31'd0, hit_valid}, 32'd1);
    checkOutput("bp_hold_idx", {30'd0, hit_idx}, 32'd0);
    checkOutput("bp_hold_coarse", {23'd0, hit_coarse}, 32'd50);
    checkOutput("bp_hold_int", {16'd0, hit_int}, 32'h0A0A);
    hit_ready = 1'b1;
    drain(8);
    checkOutput("bp_count", q_idx.size(), exp_n);
    for (int i = 0; i < q_idx.size(); i++)
      checkOutput($sformatf("bp_idx%0d", i), {30'd0, q_idx[i]}, i);

    $display("[TB] reset mid-frame in REARM");
    hit_ready = 1'b0;
    applyStimulus(197, NONE, NONE, 16'h0197, 16'h0000, 16'h0000, 200);
    checkOutput("pre_reset_rearm", {31'd0, spad_rearm}, 32'd1);
    checkOutput("pre_reset_valid", {31'd0, hit_valid}, 32'd1);
    rst_auto = 1'b1;
    #1;
    checkOutput("reset_abort_outputs",
                {TDC_start, spad_rearm, hit_valid, frame_done, hit_ovf, hit_idx, hit_coarse, hit_int},
                32'd0);
    done_fc = -1;
    drain(2);
    checkOutput("reset_no_done", done_fc, -1);
    rst_auto  = 1'b0;
    hit_ready = 1'b1;
    drain(2);
    applyStimulus(50, NONE, NONE, 16'h00AA, 16'h0000, 16'h0000, NONE);
    checkOutput("post_reset_done_fc", done_fc, 511);
    drain(4);
    checkOutput("post_reset_count", q_idx.size(), 1);
    if (q_idx.size() >= 1) begin
      checkOutput("post_reset_idx", {30'd0, q_idx[0]}, 32'd0);
      checkOutput("post_reset_coarse", {23'd0, q_coarse[0]}, 32'd50);
      checkOutput("post_reset_int", {16'd0, q_int[0]}, 32'h00AA);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
